// File: rtl/bsg_vanilla_pkg.sv
// Request type and default credit count shared by the vanilla core's
// remote-request path.
package bsg_vanilla_pkg;

   localparam int vanilla_remote_out_credits_gp = 16;

   typedef struct packed {
      logic        write_not_read;
      logic        is_amo_op;
      logic        icache_fetch;
      logic [1:0]  amo_type;
      logic [3:0]  mask;
      logic [4:0]  reg_id;
      logic [31:0] data;
      logic [31:0] addr;
   } remote_req_s;

endpackage

// File: rtl/remote_req_buffer_pkg.sv
// Shared constants and helpers for remote_req_buffer. Optional stall
// statistics are enabled with macro REMOTE_REQ_BUFFER_STATS_EN.
`ifndef BSG_WIDTH
`define BSG_WIDTH(x) ($clog2((x)+1))
`endif

package remote_req_buffer_pkg;

   localparam int stall_cnt_width_lp = 32;

   // Counters stick at all-ones rather than wrapping back to zero.
   function automatic logic [stall_cnt_width_lp-1:0] sat_inc(
      input logic [stall_cnt_width_lp-1:0] value
   );
      return (value == '1) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/remote_req_buffer_if.sv
// Handshake bundle between the load/store unit, the request buffer and the
// network transmit side.
interface remote_req_buffer_if;
   import bsg_vanilla_pkg::*;

   remote_req_s remote_req_i;
   logic        remote_req_v_i;
   logic        remote_req_ready_o;
   remote_req_s remote_req_o;
   logic        remote_req_v_o;
   logic        remote_req_yumi_i;
   logic        credit_return_i;

   modport slave (
      input  remote_req_i, remote_req_v_i, remote_req_yumi_i, credit_return_i,
      output remote_req_ready_o, remote_req_o, remote_req_v_o
   );

   modport master (
      output remote_req_i, remote_req_v_i, remote_req_yumi_i, credit_return_i,
      input  remote_req_ready_o, remote_req_o, remote_req_v_o
   );

endinterface

// File: rtl/remote_req_buffer_fifo.sv
// remote_req_fifo: 1r1w circular buffer of els_p requests with
// ready/valid enqueue and valid/yumi dequeue.
module remote_req_fifo
   import bsg_vanilla_pkg::*;
#(
   parameter  int els_p        = 2,
   localparam int ptr_width_lp = $clog2(els_p),
   localparam int cnt_width_lp = $clog2(els_p + 1)
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  remote_req_s data_i,
   input  logic        v_i,
   output logic        ready_o,
   output remote_req_s data_o,
   output logic        v_o,
   input  logic        yumi_i
);

   localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);
   localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(els_p);

   remote_req_s                mem_q [els_p];
   logic [ptr_width_lp-1:0]    rptr_q, rptr_d, wptr_q, wptr_d;
   logic [cnt_width_lp-1:0]    count_q, count_d;
   logic                       enq, deq;

   assign ready_o = (count_q != full_cnt_lp);
   assign v_o     = (count_q != '0);
   assign enq     = v_i & ready_o;
   assign deq     = yumi_i & v_o;
   assign data_o  = mem_q[rptr_q];

   // Pointers wrap explicitly so non-power-of-two depths work too.
   always_comb begin
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      if (deq) rptr_d = (rptr_q == last_ptr_lp) ? '0 : rptr_q + 1'b1;
      if (enq) wptr_d = (wptr_q == last_ptr_lp) ? '0 : wptr_q + 1'b1;
      case ({enq, deq})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/remote_req_buffer.sv
// Buffers outgoing remote requests and meters them onto the network with
// an outstanding-request credit count. Stall counters need REMOTE_REQ_BUFFER_STATS_EN.
module remote_req_buffer
   import bsg_vanilla_pkg::*;
   import remote_req_buffer_pkg::*;
#(
   parameter  int els_p             = 2,
   parameter  int max_out_credits_p = vanilla_remote_out_credits_gp,
   localparam int credit_width_lp   = `BSG_WIDTH(max_out_credits_p)
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   remote_req_buffer_if.slave            bus_if,
   output logic [credit_width_lp-1:0]    out_credits_o,
   output logic                          idle_o,
   output logic [stall_cnt_width_lp-1:0] req_stall_cnt_o,
   output logic [stall_cnt_width_lp-1:0] credit_stall_cnt_o
);

   localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

   logic                       fifo_ready, fifo_v, enq, deq, credits_avail;
   remote_req_s                fifo_data;
   logic [credit_width_lp-1:0] credits_q, credits_d;

   remote_req_fifo #(.els_p(els_p)) fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .data_i  (bus_if.remote_req_i),
      .v_i     (enq),
      .ready_o (fifo_ready),
      .data_o  (fifo_data),
      .v_o     (fifo_v),
      .yumi_i  (deq)
   );

   // Handshakes are forced low while reset is held so nothing leaks out.
   assign credits_avail             = (credits_q != '0);
   assign bus_if.remote_req_ready_o = ~reset_i & fifo_ready;
   assign bus_if.remote_req_v_o     = ~reset_i & fifo_v & credits_avail;
   assign bus_if.remote_req_o       = fifo_data;
   assign enq                       = bus_if.remote_req_v_i & bus_if.remote_req_ready_o;
   assign deq                       = bus_if.remote_req_yumi_i & bus_if.remote_req_v_o;
   assign out_credits_o             = credits_q;
   assign idle_o                    = ~reset_i & ~fifo_v & (credits_q == max_credits_lp);

   always_comb begin
      credits_d = credits_q;
      if (deq & ~bus_if.credit_return_i)
         credits_d = credits_q - 1'b1;
      else if (bus_if.credit_return_i & ~deq & (credits_q != max_credits_lp))
         credits_d = credits_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) credits_q <= max_credits_lp;
      else         credits_q <= credits_d;
   end

`ifdef REMOTE_REQ_BUFFER_STATS_EN
   logic [stall_cnt_width_lp-1:0] req_stall_q, req_stall_d;
   logic [stall_cnt_width_lp-1:0] credit_stall_q, credit_stall_d;

   always_comb begin
      req_stall_d    = req_stall_q;
      credit_stall_d = credit_stall_q;
      if (bus_if.remote_req_v_i & ~bus_if.remote_req_ready_o) req_stall_d    = sat_inc(req_stall_q);
      if (fifo_v & ~credits_avail)                            credit_stall_d = sat_inc(credit_stall_q);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         req_stall_q    <= '0;
         credit_stall_q <= '0;
      end else begin
         req_stall_q    <= req_stall_d;
         credit_stall_q <= credit_stall_d;
      end
   end

   assign req_stall_cnt_o    = req_stall_q;
   assign credit_stall_cnt_o = credit_stall_q;
`else
   assign req_stall_cnt_o    = '0;
   assign credit_stall_cnt_o = '0;
`endif

`ifndef SYNTHESIS
   // Protocol misuse by the neighbours; checked only outside reset.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert (!(bus_if.remote_req_yumi_i && !bus_if.remote_req_v_o))
            else $error("remote_req_buffer: yumi while remote_req_v_o low");
         assert (!(bus_if.credit_return_i && (credits_q == max_credits_lp)))
            else $error("remote_req_buffer: credit returned at max credits");
         assert (!(bus_if.remote_req_yumi_i && !credits_avail && !bus_if.credit_return_i))
            else $error("remote_req_buffer: out_credits_o underflow");
      end
   end
`endif

endmodule

// File: tb/tb_remote_req_buffer.sv
// Directed and randomized bench for remote_req_buffer against a queue-based
// reference model of the buffer and credit rules.
module tb_remote_req_buffer;
   import bsg_vanilla_pkg::*;

   localparam int ELS  = 2;
   localparam int MAXC = 16;
   localparam int CW   = $clog2(MAXC + 1);

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [CW-1:0] outCredits;
   logic          idle;
   logic [31:0]   reqStallCnt, creditStallCnt;

   remote_req_buffer_if busIf();

   remote_req_buffer #(.els_p(ELS), .max_out_credits_p(MAXC)) dut (
      .clk_i              (clock),
      .reset_i            (reset),
      .bus_if             (busIf),
      .out_credits_o      (outCredits),
      .idle_o             (idle),
      .req_stall_cnt_o    (reqStallCnt),
      .credit_stall_cnt_o (creditStallCnt)
   );

   always #5 clock = ~clock;

   remote_req_s modelQ[$];
   int          modelCredits = MAXC;
   longint      modelReqStall = 0;
   longint      modelCreditStall = 0;
   int          compared = 0;
   int          mismatched = 0;
   remote_req_s blankReq = '0;

   function automatic remote_req_s makeReq(input int kind);
      remote_req_s r;
      r                = '0;
      r.addr           = $urandom;
      r.data           = $urandom;
      r.reg_id         = 5'($urandom_range(0, 31));
      r.mask           = 4'hF;
      r.write_not_read = (kind == 1) || (kind == 2);
      r.is_amo_op      = (kind == 2);
      r.amo_type       = (kind == 2) ? 2'($urandom_range(0, 3)) : 2'b00;
      r.icache_fetch   = (kind == 3);
      return r;
   endfunction

   function automatic logic expReady();
      return !reset && (modelQ.size() < ELS);
   endfunction

   function automatic logic expValid();
      return !reset && (modelQ.size() > 0) && (modelCredits > 0);
   endfunction

   function automatic logic expIdle();
      return !reset && (modelQ.size() == 0) && (modelCredits == MAXC);
   endfunction

   function automatic logic [31:0] satCount(input longint c);
`ifdef REMOTE_REQ_BUFFER_STATS_EN
      return (c > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(c);
`else
      return (c < 0) ? 32'd1 : 32'd0;
`endif
   endfunction

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkReq(input string tag, input remote_req_s obs, input remote_req_s exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string phase);
      checkVal({phase, ".ready"}, 64'(busIf.remote_req_ready_o), 64'(expReady()));
      checkVal({phase, ".valid"}, 64'(busIf.remote_req_v_o), 64'(expValid()));
      checkVal({phase, ".idle"}, 64'(idle), 64'(expIdle()));
      checkVal({phase, ".credits"}, 64'(outCredits), 64'(modelCredits));
      checkVal({phase, ".reqStall"}, 64'(reqStallCnt), 64'(satCount(modelReqStall)));
      checkVal({phase, ".creditStall"}, 64'(creditStallCnt), 64'(satCount(modelCreditStall)));
      if (expValid()) checkReq({phase, ".head"}, busIf.remote_req_o, modelQ[0]);
   endtask

   // One clock of stimulus; yumi and credit returns are only offered when legal.
   task automatic applyStimulus(input string phase, input logic rst, input logic v,
                                input remote_req_s req, input logic yumi, input logic cr);
      logic rdy, vo, yumiEff, crEff, hasData, noCredit;
      reset    = rst;
      rdy      = expReady();
      vo       = expValid();
      hasData  = modelQ.size() > 0;
      noCredit = modelCredits == 0;
      yumiEff  = yumi && vo;
      crEff    = cr && !rst && (modelCredits < MAXC);
      busIf.remote_req_i      = req;
      busIf.remote_req_v_i    = v;
      busIf.remote_req_yumi_i = yumiEff;
      busIf.credit_return_i   = crEff;
      @(posedge clock);
      if (rst) begin
         modelQ.delete();
         modelCredits     = MAXC;
         modelReqStall    = 0;
         modelCreditStall = 0;
      end else begin
         if (v && !rdy)           modelReqStall++;
         if (hasData && noCredit) modelCreditStall++;
         if (yumiEff) void'(modelQ.pop_front());
         if (v && rdy) modelQ.push_back(req);
         modelCredits = modelCredits - int'(yumiEff) + int'(crEff);
      end
      @(negedge clock);
      checkOutput(phase);
   endtask

   initial begin
      remote_req_s reqA, reqB, reqC, reqI, reqS;
      busIf.remote_req_i      = '0;
      busIf.remote_req_v_i    = 1'b0;
      busIf.remote_req_yumi_i = 1'b0;
      busIf.credit_return_i   = 1'b0;

      applyStimulus("reset", 1'b1, 1'b0, blankReq, 1'b0, 1'b0);
      applyStimulus("reset", 1'b1, 1'b1, makeReq(0), 1'b1, 1'b1);
      applyStimulus("postReset", 1'b0, 1'b0, blankReq, 1'b0, 1'b0);
      checkVal("postReset.idleConst", 64'(idle), 64'd1);

      // Two loads back to back with the network always accepting.
      reqA = makeReq(0);
      reqB = makeReq(0);
      applyStimulus("loadsAB", 1'b0, 1'b1, reqA, 1'b1, 1'b0);
      checkReq("loadsAB.headA", busIf.remote_req_o, reqA);
      checkVal("loadsAB.credits16", 64'(outCredits), 64'd16);
      applyStimulus("loadsAB", 1'b0, 1'b1, reqB, 1'b1, 1'b0);
      checkReq("loadsAB.headB", busIf.remote_req_o, reqB);
      checkVal("loadsAB.credits15", 64'(outCredits), 64'd15);
      applyStimulus("loadsAB", 1'b0, 1'b0, blankReq, 1'b1, 1'b0);
      checkVal("loadsAB.credits14", 64'(outCredits), 64'd14);
      applyStimulus("loadsAB", 1'b0, 1'b0, blankReq, 1'b0, 1'b1);
      applyStimulus("loadsAB", 1'b0, 1'b0, blankReq, 1'b0, 1'b1);

      // Fill the two-entry buffer and hold a third request in stall.
      reqC = makeReq(1);
      applyStimulus("fullStall", 1'b0, 1'b1, makeReq(0), 1'b0, 1'b0);
      applyStimulus("fullStall", 1'b0, 1'b1, makeReq(1), 1'b0, 1'b0);
      checkVal("fullStall.readyLow", 64'(busIf.remote_req_ready_o), 64'd0);
      for (int i = 0; i < 3; i++) applyStimulus("fullStall", 1'b0, 1'b1, reqC, 1'b0, 1'b0);
`ifdef REMOTE_REQ_BUFFER_STATS_EN
      checkVal("fullStall.stallCnt3", 64'(reqStallCnt), 64'd3);
`endif
      applyStimulus("fullStall", 1'b0, 1'b1, reqC, 1'b1, 1'b0);
      applyStimulus("fullStall", 1'b0, 1'b1, reqC, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus("fullDrain", 1'b0, 1'b0, blankReq, 1'b1, 1'b0);
      for (int i = 0; i < MAXC && modelCredits < MAXC; i++)
         applyStimulus("fullDrain", 1'b0, 1'b0, blankReq, 1'b0, 1'b1);

      // Exhaust every credit; the waiting head must hold until a return.
      for (int i = 0; i < MAXC + 2; i++)
         applyStimulus("noCredit", 1'b0, 1'b1, makeReq(i % 4), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus("noCredit", 1'b0, 1'b0, blankReq, 1'b1, 1'b0);
      checkVal("noCredit.validLow", 64'(busIf.remote_req_v_o), 64'd0);
      checkVal("noCredit.credits0", 64'(outCredits), 64'd0);
      applyStimulus("noCredit", 1'b0, 1'b0, blankReq, 1'b1, 1'b1);
      checkVal("noCredit.validAfterReturn", 64'(busIf.remote_req_v_o), 64'd1);
      applyStimulus("noCredit", 1'b0, 1'b0, blankReq, 1'b1, 1'b0);
      for (int i = 0; i < 8 && modelQ.size() > 0; i++)
         applyStimulus("noCreditDrain", 1'b0, 1'b0, blankReq, 1'b1, 1'b1);

      // Coincident yumi and credit return at five credits.
      for (int i = 0; i < MAXC && modelCredits < 5; i++)
         applyStimulus("coincide", 1'b0, 1'b0, blankReq, 1'b0, 1'b1);
      applyStimulus("coincide", 1'b0, 1'b1, makeReq(2), 1'b0, 1'b0);
      checkVal("coincide.credits5Before", 64'(outCredits), 64'd5);
      applyStimulus("coincide", 1'b0, 1'b0, blankReq, 1'b1, 1'b1);
      checkVal("coincide.credits5After", 64'(outCredits), 64'd5);
      for (int i = 0; i < MAXC + 2 && modelCredits < MAXC; i++)
         applyStimulus("coincide", 1'b0, 1'b0, blankReq, 1'b0, 1'b1);

      // Reset while two requests are buffered.
      applyStimulus("midReset", 1'b0, 1'b1, makeReq(0), 1'b0, 1'b0);
      applyStimulus("midReset", 1'b0, 1'b1, makeReq(1), 1'b0, 1'b0);
      applyStimulus("midReset", 1'b1, 1'b0, blankReq, 1'b0, 1'b0);
      applyStimulus("midReset", 1'b0, 1'b0, blankReq, 1'b1, 1'b0);
      checkVal("midReset.validLow", 64'(busIf.remote_req_v_o), 64'd0);
      checkVal("midReset.credits16", 64'(outCredits), 64'd16);
      checkVal("midReset.idle", 64'(idle), 64'd1);

      // Instruction fetch followed by a store, then both responses return.
      reqI = makeReq(3);
      reqS = makeReq(1);
      applyStimulus("fetchStore", 1'b0, 1'b1, reqI, 1'b1, 1'b0);
      checkReq("fetchStore.headI", busIf.remote_req_o, reqI);
      applyStimulus("fetchStore", 1'b0, 1'b1, reqS, 1'b1, 1'b0);
      checkReq("fetchStore.headS", busIf.remote_req_o, reqS);
      applyStimulus("fetchStore", 1'b0, 1'b0, blankReq, 1'b1, 1'b0);
      checkVal("fetchStore.credits14", 64'(outCredits), 64'd14);
      applyStimulus("fetchStore", 1'b0, 1'b0, blankReq, 1'b0, 1'b1);
      applyStimulus("fetchStore", 1'b0, 1'b0, blankReq, 1'b0, 1'b1);
      checkVal("fetchStore.idle", 64'(idle), 64'd1);

      for (int i = 0; i < 600; i++) begin
         applyStimulus("random",
                       ($urandom_range(0, 63) == 0),
                       1'($urandom_range(0, 1)),
                       makeReq(int'($urandom_range(0, 3))),
                       ($urandom_range(0, 2) != 0),
                       ($urandom_range(0, 2) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
